exe_muldiv_alu: RTL
===================

Name: exe_muldiv_alu

Overview:
- Execute-stage datapath: consumes Val1, Val2 and EXE_CMD from the ID/EX pipeline register and produces ALU_result for the EX/MEM register.
- Single-cycle logic/arith/shift ops complete combinationally.
- Signed MUL/DIV run on an iterative radix-2 engine. The block asserts stall, which freezes PC, IF/ID and ID/EX, until the result is ready.

Parameters:
- DATA_W, 32, operand/result width.
- CNT_W, 5, iteration counter width, equal to clog2(DATA_W).

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- flush  in  1  synchronous abort of any in-flight MUL/DIV
- EXE_CMD  in  4  operation code
- Val1  in  DATA_W  operand A / dividend / shift source
- Val2  in  DATA_W  operand B / divisor / shift amount in [4:0]
- ALU_result  out  DATA_W  result to EX/MEM
- stall  out  1  high while a MUL/DIV occupies EXE; freezes upstream
- busy  out  1  high in BUSY state (debug/perf counter)

Behaviour:
- Opcodes:
  - ADD 0000, SUB 0010, AND 0100, OR 0101, NOR 0110, XOR 0111
  - SLL 1000, SRL 1001, SRA 1010
  - MUL 1100, DIV 1101
  - Any other opcode yields result 0.
- Arithmetic wraps modulo 2^DATA_W. No overflow flag. Shift amount is Val2[4:0].
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - Non-MUL/DIV opcode: ALU_result is the combinational result of the current inputs; stall=0.
  - MUL/DIV opcode: stall=1 in the same cycle (combinational). On the clock edge, latch |Val1| and |Val2|, the result sign, the remainder sign and the op; set cnt=0; go to BUSY.
- BUSY:
  - stall=1, busy=1; one iteration per cycle.
  - MUL: shift-add on the magnitude product, 2*DATA_W accumulator.
  - DIV: restoring shift-subtract.
  - Exit when cnt==DATA_W-1 → DONE. That is exactly DATA_W BUSY cycles.
- DONE:
  - stall=0. ALU_result = res_q, i.e. the sign-corrected low product or the quotient.
  - Next edge → IDLE unconditionally. The upstream register loads the next instruction on that same edge, so the op is never re-issued.
- Timing: stall is high for DATA_W+1 cycles (33). The result is visible in cycle DATA_W+2 after issue.
- Multiply result: MUL returns the low DATA_W bits of the signed product.
- DIV rules:
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
  - Divisor 0: quotient = all ones, remainder = Val1, same latency.
  - Most-negative / -1: quotient = 0x80000000, remainder = 0.
- flush: any state → IDLE next edge; res_q untouched; stall=0 from the following cycle. In the flush cycle itself, stall follows the current state. flush in IDLE with a MUL/DIV opcode does not start the engine.
- rst: mid-operation or otherwise, immediately sets state=IDLE, cnt=0, res_q=0, internal accumulators=0.
  - Outputs during reset: stall=0, busy=0.
  - ALU_result = combinational result of the inputs, or 0 if the opcode is MUL/DIV.
- EXE_CMD, Val1 and Val2 changing during BUSY are ignored; operands are latched at issue.

Optional Feature:
- Macro: MULDIV_HI_EN.
- Defined:
  - Adds output hi [DATA_W] and opcode MFHI 1110. hi is a register loaded in DONE with the high product bits (MUL) or the remainder (DIV); reset 0.
  - MFHI is single-cycle: ALU_result = hi. hi is unchanged by flush.
- Undefined: no hi port or register. 1110 decodes as "other" (result 0). The remainder and high product are discarded.

Decomposition:
- Shared package (exe_pkg):
  - EXE_CMD opcode localparams.
  - FSM state enum.
  - DATA_W default.
- One sub-module, muldiv_iter:
  - Contains the FSM, counter, accumulators and sign correction.
  - Ports: start, op, a, b, flush, done, busy, result (plus hi_result under the macro).
  - The top holds the combinational ALU, the result mux and stall generation.

Test Plan:
- ALU sweep: ADD 7+(-3) → 4. SUB 5-9 → 0xFFFFFFFC. NOR 0,0 → 0xFFFFFFFF. SRA 0x80000000 by 4 → 0xF8000000. All with stall=0 every cycle.
- MUL -6*7:
  - stall rises in the issue cycle and stays high exactly 33 cycles.
  - DONE cycle shows 0xFFFFFFD6 with stall=0; the next cycle is back in IDLE.
- DIV -7/2 → quotient 0xFFFFFFFD (-3); with MULDIV_HI_EN, hi=0xFFFFFFFF (-1). DIV 5/0 → 0xFFFFFFFF. DIV 0x80000000/-1 → 0x80000000.
- Back-to-back MUL then ADD (ID/EX held by stall): ADD result appears the cycle after DONE. MUL is not executed twice; busy pulses exactly 32 cycles.
- flush at BUSY cycle 10 of a DIV → IDLE next edge, stall=0. res_q keeps its prior value; a subsequent ADD 1+1 → 2.
- rst asserted asynchronously mid-BUSY → stall/busy drop immediately. After release, MUL 3*4 → 12 with full 33-cycle stall.

Source files
------------

// File: rtl/exe_pkg.sv
// Shared definitions for the execute stage: opcodes, mul/div FSM states,
// default datapath width.
// Optional build macro: MULDIV_HI_EN (adds the MFHI opcode / hi register).
package exe_pkg;

    localparam int DATA_W_DEF = 32;

    localparam logic [3:0] CMD_ADD  = 4'b0000;
    localparam logic [3:0] CMD_SUB  = 4'b0010;
    localparam logic [3:0] CMD_AND  = 4'b0100;
    localparam logic [3:0] CMD_OR   = 4'b0101;
    localparam logic [3:0] CMD_NOR  = 4'b0110;
    localparam logic [3:0] CMD_XOR  = 4'b0111;
    localparam logic [3:0] CMD_SLL  = 4'b1000;
    localparam logic [3:0] CMD_SRL  = 4'b1001;
    localparam logic [3:0] CMD_SRA  = 4'b1010;
    localparam logic [3:0] CMD_MUL  = 4'b1100;
    localparam logic [3:0] CMD_DIV  = 4'b1101;
    localparam logic [3:0] CMD_MFHI = 4'b1110;

    // Engine operation select
    localparam logic MD_MUL = 1'b0;
    localparam logic MD_DIV = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } md_state_e;

endpackage

// File: rtl/muldiv_iter.sv
// Iterative radix-2 signed multiply / divide engine.
// Works on magnitudes: shift-add for MUL, restoring shift-subtract for DIV,
// sharing one 2*DATA_W accumulator ({hi, lo} or {remainder, quotient}).
// Sign correction is applied on the final iteration so res_q is ready in DONE.
// Optional build macro: MULDIV_HI_EN (exports high product / remainder).
module muldiv_iter
    import exe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic              i_op,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic              i_flush,
    output logic              o_done,
    output logic              o_busy,
    output logic [DATA_W-1:0] o_result
`ifdef MULDIV_HI_EN
    ,
    output logic [DATA_W-1:0] o_hi_result
`endif
);

    md_state_e             r_state;
    md_state_e             w_state_nxt;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_op;
    logic                  r_res_neg;
    logic                  r_bz;
    logic [DATA_W-1:0]     r_opnd;
    logic [DATA_W-1:0]     r_res;
    logic [2*DATA_W-1:0]   r_acc;
    logic [2*DATA_W-1:0]   w_acc_nxt;
    logic [DATA_W:0]       w_sum;
    logic [DATA_W:0]       w_rsh;
    logic [DATA_W:0]       w_diff;
    logic [DATA_W-1:0]     w_a_mag;
    logic [DATA_W-1:0]     w_b_mag;
    logic [DATA_W-1:0]     w_lo;
    logic [DATA_W-1:0]     w_res;
    logic                  w_a_neg;
    logic                  w_b_neg;
    logic                  w_last;
`ifdef MULDIV_HI_EN
    logic                  r_rem_neg;
    logic [DATA_W-1:0]     r_hi_res;
    logic [DATA_W-1:0]     w_hi;
    logic [DATA_W-1:0]     w_acc_hi;
`endif

    assign w_a_neg = i_a[DATA_W-1];
    assign w_b_neg = i_b[DATA_W-1];
    assign w_a_mag = w_a_neg ? -i_a : i_a;
    assign w_b_mag = w_b_neg ? -i_b : i_b;
    assign w_last  = (r_cnt == CNT_W'(DATA_W - 1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next state: flush wins everywhere; a flush in IDLE suppresses the start
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (i_start && !i_flush) w_state_nxt = ST_BUSY;
            ST_BUSY: begin
                if (i_flush)     w_state_nxt = ST_IDLE;
                else if (w_last) w_state_nxt = ST_DONE;
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // One radix-2 step: shift-add for MUL, restoring subtract for DIV
    always_comb begin
        w_sum  = {1'b0, r_acc[2*DATA_W-1:DATA_W]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
        w_rsh  = r_acc[2*DATA_W-1:DATA_W-1];
        w_diff = w_rsh - {1'b0, r_opnd};
        if (r_op == MD_DIV) begin
            if (!w_diff[DATA_W]) w_acc_nxt = {w_diff[DATA_W-1:0], r_acc[DATA_W-2:0], 1'b1};
            else                 w_acc_nxt = {w_rsh[DATA_W-1:0],  r_acc[DATA_W-2:0], 1'b0};
        end else begin
            w_acc_nxt = {w_sum, r_acc[DATA_W-1:1]};
        end
    end

    // Sign correction of the final step. The low half of a negated 2W-bit
    // product only depends on the low half, so MUL and DIV share it.
    always_comb begin
        w_lo  = w_acc_nxt[DATA_W-1:0];
        w_res = r_bz ? '1 : (r_res_neg ? -w_lo : w_lo);
`ifdef MULDIV_HI_EN
        w_acc_hi = w_acc_nxt[2*DATA_W-1:DATA_W];
        if (r_op == MD_DIV)
            w_hi = r_rem_neg ? -w_acc_hi : w_acc_hi;
        else
            w_hi = r_res_neg ? (~w_acc_hi + DATA_W'(w_lo == '0)) : w_acc_hi;
`endif
    end

    // Operand latch at issue, iteration in BUSY, result capture on last step
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_op      <= MD_MUL;
            r_res_neg <= 1'b0;
            r_bz      <= 1'b0;
            r_opnd    <= '0;
            r_acc     <= '0;
            r_res     <= '0;
`ifdef MULDIV_HI_EN
            r_rem_neg <= 1'b0;
            r_hi_res  <= '0;
`endif
        end else if (!i_flush) begin
            if (r_state == ST_IDLE && i_start) begin
                r_op      <= i_op;
                r_res_neg <= w_a_neg ^ w_b_neg;
                r_bz      <= (i_op == MD_DIV) && (i_b == '0);
                r_opnd    <= (i_op == MD_DIV) ? w_b_mag : w_a_mag;
                r_acc     <= {{DATA_W{1'b0}}, ((i_op == MD_DIV) ? w_a_mag : w_b_mag)};
                r_cnt     <= '0;
`ifdef MULDIV_HI_EN
                r_rem_neg <= w_a_neg;
`endif
            end else if (r_state == ST_BUSY) begin
                r_acc <= w_acc_nxt;
                r_cnt <= r_cnt + 1'b1;
                if (w_last) begin
                    r_res <= w_res;
`ifdef MULDIV_HI_EN
                    r_hi_res <= w_hi;
`endif
                end
            end
        end
    end

    assign o_done   = (r_state == ST_DONE);
    assign o_busy   = (r_state == ST_BUSY);
    assign o_result = r_res;
`ifdef MULDIV_HI_EN
    assign o_hi_result = r_hi_res;
`endif

endmodule

// File: rtl/exe_muldiv_alu.sv
// Execute-stage ALU: single-cycle logic/arith/shift ops plus an iterative
// signed MUL/DIV engine that holds stall until its result is in DONE.
// Optional build macro: MULDIV_HI_EN (hi output register and MFHI opcode).
module exe_muldiv_alu
    import exe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [3:0]        EXE_CMD,
    input  logic [DATA_W-1:0] Val1,
    input  logic [DATA_W-1:0] Val2,
    output logic [DATA_W-1:0] ALU_result,
    output logic              stall,
    output logic              busy
`ifdef MULDIV_HI_EN
    ,
    output logic [DATA_W-1:0] hi
`endif
);

    logic [DATA_W-1:0] w_alu;
    logic [DATA_W-1:0] w_md_res;
    logic [4:0]        w_shamt;
    logic              w_is_md;
    logic              w_md_done;
    logic              w_md_busy;
    logic              w_md_idle;
`ifdef MULDIV_HI_EN
    logic [DATA_W-1:0] w_md_hi;
    logic [DATA_W-1:0] r_hi;
`endif

    assign w_shamt   = Val2[4:0];
    assign w_is_md   = (EXE_CMD == CMD_MUL) || (EXE_CMD == CMD_DIV);
    assign w_md_idle = !w_md_busy && !w_md_done;

    muldiv_iter #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_md (
        .clk         (clk),
        .rst         (rst),
        .i_start     (w_is_md),
        .i_op        (EXE_CMD == CMD_DIV),
        .i_a         (Val1),
        .i_b         (Val2),
        .i_flush     (flush),
        .o_done      (w_md_done),
        .o_busy      (w_md_busy),
        .o_result    (w_md_res)
`ifdef MULDIV_HI_EN
        ,
        .o_hi_result (w_md_hi)
`endif
    );

    // Single-cycle ALU; MUL/DIV and unknown opcodes read as zero here
    always_comb begin
        w_alu = '0;
        case (EXE_CMD)
            CMD_ADD:  w_alu = Val1 + Val2;
            CMD_SUB:  w_alu = Val1 - Val2;
            CMD_AND:  w_alu = Val1 & Val2;
            CMD_OR:   w_alu = Val1 | Val2;
            CMD_NOR:  w_alu = ~(Val1 | Val2);
            CMD_XOR:  w_alu = Val1 ^ Val2;
            CMD_SLL:  w_alu = Val1 << w_shamt;
            CMD_SRL:  w_alu = Val1 >> w_shamt;
            CMD_SRA:  w_alu = $signed(Val1) >>> w_shamt;
`ifdef MULDIV_HI_EN
            CMD_MFHI: w_alu = r_hi;
`endif
            default:  w_alu = '0;
        endcase
    end

`ifdef MULDIV_HI_EN
    // hi takes the high product / remainder as the engine leaves DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                      r_hi <= '0;
        else if (w_md_done && !flush) r_hi <= w_md_hi;
    end
    assign hi = r_hi;
`endif

    // Stall covers the issue cycle and all BUSY cycles; forced low in reset
    assign stall      = !rst && (w_md_busy || (w_md_idle && w_is_md));
    assign busy       = w_md_busy;
    assign ALU_result = w_md_done ? w_md_res : w_alu;

endmodule
